// File: rtl/pe_traffic_gen_if.sv
// ---------------------------------------------------------------------------
// pe_traffic_gen_if
// Link between a processing element and the Local port of a BiNoC router.
//   ReqDnStr  : PE -> router, request to inject PacketOut
//   PacketOut : PE -> router, packet held stable while ReqDnStr is high
//   GntDnStr  : router -> PE, grant that consumes the pending packet
//   DnStrFull : router -> PE, Local input buffer full
//   PacketIn  : router -> PE, ejected packet
//   ValidIn   : router -> PE, PacketIn valid, one cycle per packet
// master = PE side, slave = router side.
// ---------------------------------------------------------------------------
interface pe_traffic_gen_if #(
  parameter int DATA_W = 32
);
  logic              ReqDnStr;
  logic              GntDnStr;
  logic              DnStrFull;
  logic [DATA_W-1:0] PacketOut;
  logic [DATA_W-1:0] PacketIn;
  logic              ValidIn;

  modport master (
    output ReqDnStr, PacketOut,
    input  GntDnStr, DnStrFull, PacketIn, ValidIn
  );

  modport slave (
    input  ReqDnStr, PacketOut,
    output GntDnStr, DnStrFull, PacketIn, ValidIn
  );
endinterface

// File: rtl/pe_traffic_gen.sv
// ---------------------------------------------------------------------------
// pe_traffic_gen
// Traffic generator and sink for one BiNoC mesh node. Injects packets
// {src_x, src_y, dst_x, dst_y, payload} into the router Local port with an
// LFSR-driven inter-packet gap until a packet budget is met, and counts
// ejected packets plus those whose destination field is not this node.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   enable_i       : start next packet (sampled in IDLE only)
//   mode_i         : 0 uniform, 1 transpose, 2 fixed, 3 bit-complement
//   fixed_dst_i    : {x,y} destination for mode 2
//   pkt_budget_i   : packets to send, 0 = unlimited
//   noc_if         : router Local-port link (master side)
//   tx_count_o     : packets granted
//   rx_count_o     : packets received
//   rx_err_o       : received packets not addressed to this node
//   done_o         : budget exhausted, sticky until reset
// ---------------------------------------------------------------------------
module pe_traffic_gen #(
  parameter int          DATA_W    = 32,
  parameter int          COORD_W   = 2,
  parameter int          MESH_X    = 4,
  parameter int          MESH_Y    = 4,
  parameter int          ROUTER_X  = 0,
  parameter int          ROUTER_Y  = 0,
  parameter int          GAP_W     = 4,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic [1:0]             mode_i,
  input  logic [2*COORD_W-1:0]   fixed_dst_i,
  input  logic [CNT_W-1:0]       pkt_budget_i,
  pe_traffic_gen_if.master       noc_if,
  output logic [CNT_W-1:0]       tx_count_o,
  output logic [CNT_W-1:0]       rx_count_o,
  output logic [CNT_W-1:0]       rx_err_o,
  output logic                   done_o
);

  localparam int                 PAY_W  = DATA_W - 4*COORD_W;
  localparam logic [COORD_W-1:0] SELF_X = COORD_W'(ROUTER_X);
  localparam logic [COORD_W-1:0] SELF_Y = COORD_W'(ROUTER_Y);

  typedef enum logic [1:0] {IDLE, BUILD, GAP, WAIT_GRANT} state_e;

  state_e              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                req_q, req_d;
  logic [DATA_W-1:0]   pkt_q, pkt_d;
  logic [CNT_W-1:0]    tx_q, tx_d, tx_inc;
  logic [CNT_W-1:0]    rx_q, rx_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic                done_q, done_d;

  logic [COORD_W-1:0]   rnd_x, rnd_y, dst_x, dst_y;
  logic [DATA_W-1:0]    pkt_build;
  logic [2*COORD_W-1:0] rx_dst;

  // Galois LFSR, taps 0xB400, free-running outside reset.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Destination and packet image; only captured in BUILD.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    rnd_x = COORD_W'(32'(lfsr_q[COORD_W-1:0]) % MESH_X);
    rnd_y = COORD_W'(32'(lfsr_q[2*COORD_W-1:COORD_W]) % MESH_Y);
    // Uniform mode never targets this node: bump x to the next column.
    if (rnd_x == SELF_X && rnd_y == SELF_Y)
      rnd_x = COORD_W'((32'(rnd_x) + 32'd1) % MESH_X);

    case (mode_i)
      2'd0:    begin dst_x = rnd_x;                    dst_y = rnd_y;                    end
      2'd1:    begin dst_x = SELF_Y;                   dst_y = SELF_X;                   end
      2'd2:    begin {dst_x, dst_y} = fixed_dst_i;                                       end
      default: begin dst_x = COORD_W'(MESH_X-1-ROUTER_X); dst_y = COORD_W'(MESH_Y-1-ROUTER_Y); end
    endcase

    pkt_build = {SELF_X, SELF_Y, dst_x, dst_y, PAY_W'(tx_q)};
  end

  assign tx_inc = (&tx_q) ? tx_q : tx_q + 1'b1;

  // Transmit FSM next state.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    req_d     = req_q;
    pkt_d     = pkt_q;
    tx_d      = tx_q;
    done_d    = done_q;

    case (state_q)
      IDLE: begin
        if (!done_q && enable_i) begin
          gap_d     = lfsr_q[15 -: GAP_W];
          gap_cnt_d = '0;
          state_d   = BUILD;
        end
      end
      BUILD: begin
        pkt_d   = pkt_build;
        state_d = GAP;
      end
      GAP: begin
        // A full Local buffer freezes the gap countdown as well as the request.
        if (!noc_if.DnStrFull) begin
          if (gap_cnt_q != gap_q) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end else begin
            req_d   = 1'b1;
            state_d = WAIT_GRANT;
          end
        end
      end
      WAIT_GRANT: begin
        if (noc_if.GntDnStr) begin
          req_d   = 1'b0;
          tx_d    = tx_inc;
          // Compare against the post-grant count so a budget lowered below
          // tx_count still terminates on this grant.
          if (pkt_budget_i != '0 && tx_inc >= pkt_budget_i)
            done_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Receive path, independent of the FSM.
  assign rx_dst = noc_if.PacketIn[DATA_W-2*COORD_W-1 -: 2*COORD_W];

  always_comb begin
    rx_d  = rx_q;
    err_d = err_q;
    if (noc_if.ValidIn) begin
      if (!(&rx_q)) rx_d = rx_q + 1'b1;
      if (rx_dst != {SELF_X, SELF_Y} && !(&err_q)) err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the synchronous reset covers every register here, so a grant seen
    // in a reset cycle is dropped with the rest of the state.
    if (rst) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      req_q     <= 1'b0;
      pkt_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      err_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // same pre-edge values.
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      req_q     <= req_d;
      pkt_q     <= pkt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign noc_if.ReqDnStr  = req_q;
  assign noc_if.PacketOut = pkt_q;
  assign tx_count_o       = tx_q;
  assign rx_count_o       = rx_q;
  assign rx_err_o         = err_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_pe_traffic_gen.sv
// ---------------------------------------------------------------------------
// tb_pe_traffic_gen
// Self-checking bench for pe_traffic_gen. A reference LFSR runs beside the
// DUT; each packet's expected image is pushed to a queue when the DUT builds
// it and popped when ReqDnStr rises. A second instance at (0,0) with a
// permanently asserted grant covers bit-complement from the mesh corner.
// ---------------------------------------------------------------------------
module tb_pe_traffic_gen;

  localparam int          DATA_W = 32;
  localparam int          COORD_W = 2;
  localparam int          MESH_X = 4;
  localparam int          MESH_Y = 4;
  localparam int          RX     = 1;
  localparam int          RY     = 2;
  localparam int          CNT_W  = 16;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 enable;
  logic [1:0]           mode;
  logic [2*COORD_W-1:0] fixed_dst;
  logic [CNT_W-1:0]     pkt_budget;
  logic [CNT_W-1:0]     tx_count, rx_count, rx_err;
  logic                 done;
  logic [CNT_W-1:0]     tx2, rx2, err2;
  logic                 done2;

  pe_traffic_gen_if #(.DATA_W(DATA_W)) noc_if  ();
  pe_traffic_gen_if #(.DATA_W(DATA_W)) noc2_if ();

  pe_traffic_gen #(
    .DATA_W(DATA_W), .COORD_W(COORD_W), .MESH_X(MESH_X), .MESH_Y(MESH_Y),
    .ROUTER_X(RX), .ROUTER_Y(RY), .GAP_W(4), .CNT_W(CNT_W), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable), .mode_i(mode),
    .fixed_dst_i(fixed_dst), .pkt_budget_i(pkt_budget), .noc_if(noc_if),
    .tx_count_o(tx_count), .rx_count_o(rx_count), .rx_err_o(rx_err), .done_o(done)
  );

  pe_traffic_gen #(
    .DATA_W(DATA_W), .COORD_W(COORD_W), .MESH_X(MESH_X), .MESH_Y(MESH_Y),
    .ROUTER_X(0), .ROUTER_Y(0), .GAP_W(4), .CNT_W(CNT_W), .LFSR_SEED(SEED)
  ) dut_corner (
    .clk(clk), .rst(rst), .enable_i(1'b1), .mode_i(2'd3),
    .fixed_dst_i(4'h0), .pkt_budget_i(16'd1), .noc_if(noc2_if),
    .tx_count_o(tx2), .rx_count_o(rx2), .rx_err_o(err2), .done_o(done2)
  );

  assign noc2_if.GntDnStr  = 1'b1;
  assign noc2_if.DnStrFull = 1'b0;
  assign noc2_if.PacketIn  = '0;
  assign noc2_if.ValidIn   = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int exp_tx   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [3:0]        last_dst;
  logic [15:0]       m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_dst(input logic [1:0] m, input logic [3:0] fx,
                                         input logic [15:0] l);
    int x, y;
    case (m)
      2'd0: begin
        x = int'(l[1:0]) % MESH_X;
        y = int'(l[3:2]) % MESH_Y;
        if (x == RX && y == RY) x = (x + 1) % MESH_X;
      end
      2'd1:    begin x = RY; y = RX; end
      2'd2:    begin x = int'(fx[3:2]); y = int'(fx[1:0]); end
      default: begin x = MESH_X - 1 - RX; y = MESH_Y - 1 - RY; end
    endcase
    return {2'(x), 2'(y)};
  endfunction

  function automatic logic [DATA_W-1:0] make_pkt(input logic [3:0] d, input int pay);
    return {2'(RX), 2'(RY), d, 24'(pay)};
  endfunction

  function automatic logic [DATA_W-1:0] rx_pkt(input logic [3:0] d);
    return {4'($urandom), d, 24'($urandom)};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},  noc_if.ReqDnStr,  0);
    check({tag, "_pkt"},  noc_if.PacketOut, 0);
    check({tag, "_tx"},   tx_count,         0);
    check({tag, "_rx"},   rx_count,         0);
    check({tag, "_err"},  rx_err,           0);
    check({tag, "_done"}, done,             0);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    noc_if.GntDnStr  = 1'b0;
    noc_if.DnStrFull = 1'b0;
    noc_if.ValidIn   = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_tx = 0;
    exp_q.delete();
    check_reset_vals("reset");
  endtask

  // Entered on a negedge with the DUT due to sit in IDLE at the next edge.
  task automatic run_packet(input int full_cycles, input int grant_delay,
                            input bit rx_on_grant, input bit rst_in_wait);
    int g, n;
    bit bad;
    logic [DATA_W-1:0] exp_pkt;
    enable = 1'b1;
    g = int'(m_lfsr[15:12]);
    @(negedge clk);                       // IDLE edge taken, BUILD next
    exp_q.push_back(make_pkt(exp_dst(mode, fixed_dst, m_lfsr), exp_tx));
    @(negedge clk);                       // BUILD edge taken
    if (full_cycles > 0) begin
      bad = 1'b0;
      repeat (g) begin
        @(negedge clk);
        if (noc_if.ReqDnStr) bad = 1'b1;
      end
      noc_if.DnStrFull = 1'b1;            // full on the edge the countdown ends
      repeat (full_cycles) begin
        @(negedge clk);
        if (noc_if.ReqDnStr) bad = 1'b1;
      end
      check("req_while_full", bad, 0);
      noc_if.DnStrFull = 1'b0;
      @(negedge clk);
      check("req_after_full", noc_if.ReqDnStr, 1);
    end else begin
      n = 0;
      while (!noc_if.ReqDnStr && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("gap_len", n, g + 1);
    end
    last_dst = noc_if.PacketOut[27:24];
    exp_pkt = exp_q.pop_front();
    check("pkt", noc_if.PacketOut, exp_pkt);

    if (rst_in_wait) begin
      noc_if.GntDnStr = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      noc_if.GntDnStr = 1'b0;
      exp_tx = 0;
      check_reset_vals("rst_wait");
      return;
    end

    bad = 1'b0;
    repeat (grant_delay) begin
      @(negedge clk);
      if (!noc_if.ReqDnStr || noc_if.PacketOut !== exp_pkt || tx_count !== CNT_W'(exp_tx))
        bad = 1'b1;
    end
    if (grant_delay > 0) check("hold_stable", bad, 0);

    noc_if.GntDnStr = 1'b1;
    if (rx_on_grant) begin
      noc_if.PacketIn = rx_pkt(4'b1111);
      noc_if.ValidIn  = 1'b1;
    end
    @(negedge clk);
    noc_if.GntDnStr = 1'b0;
    noc_if.ValidIn  = 1'b0;
    exp_tx++;
    check("req_drop", noc_if.ReqDnStr, 0);
    check("tx_count", tx_count, exp_tx);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    logic [3:0] rx_tbl [7];
    enable = 1'b0;
    mode = 2'd2;
    fixed_dst = {2'd3, 2'd0};
    pkt_budget = 16'd3;
    noc_if.PacketIn = '0;

    // Fixed destination, budget of three, immediate grants.
    do_reset();
    for (int i = 0; i < 3; i++) run_packet(0, 0, 0, 0);
    check("hdr_fixed", noc_if.PacketOut[31:24], 8'h6C);
    check("payload_last", noc_if.PacketOut[23:0], 24'd2);
    check("budget_done", done, 1);
    check("budget_tx", tx_count, 3);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (noc_if.ReqDnStr) bad = 1'b1;
    end
    check("no_req_after_done", bad, 0);
    check("done_sticky", done, 1);

    // Transpose and bit-complement from (1,2).
    pkt_budget = 16'd1;
    mode = 2'd1;
    do_reset();
    run_packet(0, 0, 0, 0);
    check("transpose_dst", noc_if.PacketOut[27:24], 4'b1001);
    check("transpose_done", done, 1);
    mode = 2'd3;
    do_reset();
    run_packet(0, 0, 0, 0);
    check("complement_dst", noc_if.PacketOut[27:24], 4'b1001);

    // Back-pressure in GAP, withheld grant, budget lowered below tx_count.
    mode = 2'd2;
    fixed_dst = {2'd1, 2'd1};
    pkt_budget = 16'd0;
    do_reset();
    run_packet(20, 0, 0, 0);
    run_packet(0, 10, 0, 0);
    check("unlimited_not_done", done, 0);
    pkt_budget = 16'd1;
    run_packet(0, 0, 0, 0);
    check("lowered_budget_done", done, 1);

    // Uniform random over a long run.
    mode = 2'd0;
    pkt_budget = 16'd0;
    do_reset();
    bad = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      run_packet(0, 0, 0, 0);
      if (last_dst == {2'(RX), 2'(RY)} || int'(last_dst[3:2]) >= MESH_X ||
          int'(last_dst[1:0]) >= MESH_Y)
        bad = 1'b1;
    end
    check("uniform_dst_legal", bad, 0);
    check("uniform_tx", tx_count, 2000);
    check("uniform_not_done", done, 0);

    // Receive path: five to self, one misrouted, one more misrouted with a grant.
    mode = 2'd2;
    fixed_dst = {2'd0, 2'd0};
    do_reset();
    rx_tbl = '{4'b0110, 4'b0110, 4'b1111, 4'b0110, 4'b0110, 4'b0110, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      noc_if.PacketIn = rx_pkt(rx_tbl[i]);
      noc_if.ValidIn  = 1'b1;
      @(negedge clk);
      noc_if.ValidIn  = 1'b0;
      @(negedge clk);
    end
    check("rx_pre_count", rx_count, 6);
    check("rx_pre_err", rx_err, 1);
    run_packet(0, 0, 1, 0);
    check("rx_count", rx_count, 7);
    check("rx_err", rx_err, 2);

    // Reset while waiting for a grant.
    run_packet(0, 0, 0, 1);
    enable = 1'b0;

    // Corner instance at (0,0), bit-complement, budget 1.
    repeat (40) @(negedge clk);
    check("corner_dst", noc2_if.PacketOut[27:24], 4'b1111);
    check("corner_src", noc2_if.PacketOut[31:28], 4'b0000);
    check("corner_tx", tx2, 1);
    check("corner_done", done2, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
